// File: rtl/tmr_error_collector_if.sv
// Bundles the per-instance tmrError inputs with the collector's status outputs.
// The collector side takes the slave modport; whoever drives the flags takes master.
interface tmr_error_collector_if #(
    parameter int N     = 10,
    parameter int CNT_W = 16,
    parameter int IDX_W = 4
) ();
    logic [N-1:0]     tmr_err;
    logic [N-1:0]     mask;
    logic             clr;
    logic [N-1:0]     err_sticky;
    logic             err_any;
    logic [CNT_W-1:0] err_count;
    logic [IDX_W-1:0] first_idx;
    logic             first_valid;
    logic             irq;

    modport master (
        output tmr_err, mask, clr,
        input  err_sticky, err_any, err_count, first_idx, first_valid, irq
    );

    modport slave (
        input  tmr_err, mask, clr,
        output err_sticky, err_any, err_count, first_idx, first_valid, irq
    );
endinterface

// File: rtl/tmr_error_collector.sv
// Per-instance TMR error collector: syncs async flags, counts rising edges, latches first offender.
// Status updates two edges after a flag is first sampled high; no backpressure, every event is absorbed.
module tmr_error_collector #(
    parameter int N      = 10,
    parameter int CNT_W  = 16,
    parameter int THRESH = 1,
    parameter int IDX_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    tmr_error_collector_if.slave bus
);
    localparam int SUM_W = CNT_W + 1 + $clog2(N + 1);
    localparam logic [SUM_W-1:0] CNT_MAX  = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};
    localparam logic [SUM_W-1:0] THRESH_W = SUM_W'(THRESH);

    logic [N-1:0]     syncS1, syncS2, syncS3;
    logic [N-1:0]     errSticky;
    logic [CNT_W-1:0] errCount;
    logic [IDX_W-1:0] firstIdx;
    logic             firstValid;
    logic             irqReg;

    logic [N-1:0]     riseVec;
    logic [SUM_W-1:0] incSum;
    logic [SUM_W-1:0] baseCount;
    logic [SUM_W-1:0] totalSum;
    logic [CNT_W-1:0] nextCount;
    logic [IDX_W-1:0] lowIdx;
    logic             baseValid;

    // s3 follows s2 regardless of mask so unmasking a held-high flag is silent.
    always_comb begin
        riseVec   = syncS2 & ~syncS3 & ~bus.mask;
        incSum    = '0;
        for (int i = 0; i < N; i++) begin
            incSum = incSum + SUM_W'(riseVec[i]);
        end
        baseCount = bus.clr ? '0 : {{(SUM_W - CNT_W){1'b0}}, errCount};
        totalSum  = baseCount + incSum;
        nextCount = (totalSum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : totalSum[CNT_W-1:0];
        baseValid = bus.clr ? 1'b0 : firstValid;
        lowIdx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (riseVec[i]) begin
                lowIdx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncS1     <= '0;
            syncS2     <= '0;
            syncS3     <= '0;
            errSticky  <= '0;
            errCount   <= '0;
            firstIdx   <= '0;
            firstValid <= 1'b0;
            irqReg     <= 1'b0;
        end else begin
            syncS1    <= bus.tmr_err;
            syncS2    <= syncS1;
            syncS3    <= syncS2;
            errSticky <= (bus.clr ? '0 : errSticky) | riseVec;
            errCount  <= nextCount;
            // Clear is applied before this cycle's events, so a same-cycle rise re-captures.
            if (!baseValid && (riseVec != '0)) begin
                firstIdx   <= lowIdx;
                firstValid <= 1'b1;
            end else begin
                firstValid <= baseValid;
            end
            irqReg <= (baseCount < THRESH_W) && (totalSum >= THRESH_W);
        end
    end

    assign bus.err_sticky  = errSticky;
    assign bus.err_any     = |errSticky;
    assign bus.err_count   = errCount;
    assign bus.first_idx   = firstIdx;
    assign bus.first_valid = firstValid;
    assign bus.irq         = irqReg;
endmodule

// File: tb/tb_tmr_error_collector.sv
// Directed bench: table of per-step vectors on a 16-bit-counter instance, plus hand sequences
// for held inputs, saturation on a 2-bit-counter instance, and asynchronous reset.
module tb_tmr_error_collector;
    logic clk;
    logic rst;

    tmr_error_collector_if #(.N(10), .CNT_W(16), .IDX_W(4)) busA ();
    tmr_error_collector_if #(.N(10), .CNT_W(2),  .IDX_W(4)) busB ();

    tmr_error_collector #(.N(10), .CNT_W(16), .THRESH(1), .IDX_W(4)) dutA (
        .clk(clk), .rst(rst), .bus(busA)
    );
    tmr_error_collector #(.N(10), .CNT_W(2), .THRESH(1), .IDX_W(4)) dutB (
        .clk(clk), .rst(rst), .bus(busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  err;
        logic [9:0]  msk;
        logic        clr;
        int          cyc;
        logic [9:0]  sticky;
        logic [15:0] cnt;
        logic [3:0]  fidx;
        logic        fv;
        logic        irq;
    } vec_t;

    vec_t vecs[$];
    int   passCnt  = 0;
    int   totalCnt = 0;
    int   irqSeenA = 0;
    int   irqSeenB = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        irqSeenA += int'(busA.irq);
        irqSeenB += int'(busB.irq);
    endtask

    task automatic addVec(input logic [9:0] err, input logic [9:0] msk, input logic clr, input int cyc,
                          input logic [9:0] sticky, input logic [15:0] cnt, input logic [3:0] fidx,
                          input logic fv, input logic irq);
        vec_t v;
        v.err = err; v.msk = msk; v.clr = clr; v.cyc = cyc;
        v.sticky = sticky; v.cnt = cnt; v.fidx = fidx; v.fv = fv; v.irq = irq;
        vecs.push_back(v);
    endtask

    task automatic checkA(input string tag, input logic [9:0] sticky, input logic [15:0] cnt,
                          input logic [3:0] fidx, input logic fv, input logic irq);
        check({tag, ".sticky"}, 32'(busA.err_sticky), 32'(sticky));
        check({tag, ".any"},    32'(busA.err_any),    32'(|sticky));
        check({tag, ".count"},  32'(busA.err_count),  32'(cnt));
        check({tag, ".fidx"},   32'(busA.first_idx),  32'(fidx));
        check({tag, ".fvalid"}, 32'(busA.first_valid), 32'(fv));
        check({tag, ".irq"},    32'(busA.irq),        32'(irq));
    endtask

    initial begin
        int expB[5];
        int irqBase;
        expB = '{1, 2, 3, 3, 3};

        // Each row: drive inputs, advance cyc edges, then compare.
        addVec(10'h000, 10'h000, 0, 2, 10'h000, 0, 0, 0, 0);
        addVec(10'h008, 10'h000, 0, 1, 10'h000, 0, 0, 0, 0);
        addVec(10'h000, 10'h000, 0, 1, 10'h000, 0, 0, 0, 0);
        addVec(10'h000, 10'h000, 0, 1, 10'h008, 1, 3, 1, 1);
        addVec(10'h000, 10'h000, 0, 1, 10'h008, 1, 3, 1, 0);
        addVec(10'h000, 10'h000, 1, 1, 10'h000, 0, 3, 0, 0);
        addVec(10'h204, 10'h000, 0, 3, 10'h204, 2, 2, 1, 1);
        addVec(10'h000, 10'h000, 0, 3, 10'h204, 2, 2, 1, 0);
        for (int i = 0; i < 5; i++) begin
            addVec(10'h001, 10'h001, 0, 1, 10'h204, 2, 2, 1, 0);
            addVec(10'h000, 10'h001, 0, 1, 10'h204, 2, 2, 1, 0);
        end
        addVec(10'h000, 10'h001, 0, 2, 10'h204, 2, 2, 1, 0);
        addVec(10'h001, 10'h001, 0, 3, 10'h204, 2, 2, 1, 0);
        addVec(10'h001, 10'h000, 0, 2, 10'h204, 2, 2, 1, 0);
        addVec(10'h000, 10'h000, 0, 3, 10'h204, 2, 2, 1, 0);
        addVec(10'h000, 10'h204, 0, 1, 10'h204, 2, 2, 1, 0);
        addVec(10'h080, 10'h000, 0, 1, 10'h204, 2, 2, 1, 0);
        addVec(10'h000, 10'h000, 0, 1, 10'h204, 2, 2, 1, 0);
        addVec(10'h000, 10'h000, 1, 1, 10'h080, 1, 7, 1, 1);
        addVec(10'h000, 10'h000, 0, 1, 10'h080, 1, 7, 1, 0);
        addVec(10'h201, 10'h000, 0, 3, 10'h281, 3, 7, 1, 0);
        addVec(10'h000, 10'h000, 0, 3, 10'h281, 3, 7, 1, 0);

        rst = 1'b1;
        busA.tmr_err = '0; busA.mask = '0; busA.clr = 1'b0;
        busB.tmr_err = '0; busB.mask = '0; busB.clr = 1'b0;
        #12;
        checkA("reset", 10'h000, 0, 0, 0, 0);
        check("resetB.count", 32'(busB.err_count), 0);
        rst = 1'b0;

        foreach (vecs[r]) begin
            busA.tmr_err = vecs[r].err;
            busA.mask    = vecs[r].msk;
            busA.clr     = vecs[r].clr;
            for (int c = 0; c < vecs[r].cyc; c++) begin
                step();
                busA.clr = 1'b0;
            end
            checkA($sformatf("vec%0d", r), vecs[r].sticky, vecs[r].cnt, vecs[r].fidx,
                   vecs[r].fv, vecs[r].irq);
        end

        // Held-high input gives one event; re-raise after a low gap gives a second, no second irq.
        busA.clr = 1'b1;
        step();
        busA.clr = 1'b0;
        irqBase = irqSeenA;
        busA.tmr_err = 10'h008;
        for (int c = 0; c < 20; c++) step();
        check("hold.count", 32'(busA.err_count), 1);
        check("hold.irqPulses", 32'(irqSeenA - irqBase), 1);
        busA.tmr_err = 10'h000;
        step(); step();
        busA.tmr_err = 10'h008;
        for (int c = 0; c < 4; c++) step();
        busA.tmr_err = 10'h000;
        check("reraise.count", 32'(busA.err_count), 2);
        check("reraise.irqPulses", 32'(irqSeenA - irqBase), 1);
        check("reraise.fidx", 32'(busA.first_idx), 3);
        for (int c = 0; c < 3; c++) step();

        // 2-bit counter saturates at 3 and never wraps.
        for (int e = 0; e < 5; e++) begin
            busB.tmr_err = 10'h002;
            step();
            busB.tmr_err = 10'h000;
            step(); step();
            check($sformatf("sat.count%0d", e), 32'(busB.err_count), 32'(expB[e]));
            step();
        end
        check("sat.irqPulses", 32'(irqSeenB), 1);
        check("sat.sticky", 32'(busB.err_sticky), 32'h002);

        // Asynchronous reset with an event still in the synchroniser.
        busA.tmr_err = 10'h008;
        step();
        #2 rst = 1'b1;
        #1;
        checkA("midReset", 10'h000, 0, 0, 0, 0);
        busA.tmr_err = 10'h000;
        #3 rst = 1'b0;
        for (int c = 0; c < 3; c++) step();
        checkA("postReset", 10'h000, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
